// File: rtl/plic_claim_master.sv
// PLIC claim/complete initiator: one instance per hart context.
// Claims the pending interrupt over TileLink-UL, hands the ID to the core,
// then writes the same ID back to complete it.
module plic_claim_master #(
  parameter int unsigned           TL_RS     = 4,
  parameter logic [TL_RS-1:0]      SOURCE_ID = '0,
  parameter int unsigned           CONTEXT   = 0,
  parameter int unsigned           HOLDOFF   = 4
) (
  input  logic             icm_clock_i,
  input  logic             icm_resetn_i,
  // TileLink A channel
  output logic [2:0]       icm_a_opcode,
  output logic [2:0]       icm_a_param,
  output logic [3:0]       icm_a_size,
  output logic [TL_RS-1:0] icm_a_source,
  output logic [21:0]      icm_a_address,
  output logic [3:0]       icm_a_mask,
  output logic [31:0]      icm_a_data,
  output logic             icm_a_corrupt,
  output logic             icm_a_valid,
  input  logic             icm_a_ready,
  // TileLink D channel
  input  logic [2:0]       icm_d_opcode,
  input  logic [1:0]       icm_d_param,
  input  logic [3:0]       icm_d_size,
  input  logic [TL_RS-1:0] icm_d_source,
  input  logic             icm_d_denied,
  input  logic             icm_d_corrupt,
  input  logic [31:0]      icm_d_data,
  input  logic             icm_d_valid,
  output logic             icm_d_ready,
  // Core side
  input  logic             irq_i,
  output logic             claim_valid_o,
  output logic [4:0]       claim_id_o,
  input  logic             claim_ready_i,
  input  logic             complete_valid_i,
  output logic             complete_ready_o,
  output logic             err_o
);

  localparam logic [2:0]  OP_GET      = 3'd4;
  localparam logic [2:0]  OP_PUT_FULL = 3'd0;
  localparam logic [2:0]  OP_ACK      = 3'd0;
  localparam logic [2:0]  OP_ACK_DATA = 3'd1;
  localparam logic [21:0] CLAIM_ADDR  = (CONTEXT != 0) ? 22'h201004 : 22'h200004;
  localparam logic [3:0]  HOLD_LOAD   = 4'(HOLDOFF);

  typedef enum logic [2:0] {
    IDLE, CLM_REQ, CLM_RSP, DELIVER, WAIT_CMP, CMP_REQ, CMP_RSP, HOLD
  } state_e;

  state_e      state_q, state_d;
  logic        a_valid_q, a_valid_d;
  logic [2:0]  a_opcode_q, a_opcode_d;
  logic [31:0] a_data_q, a_data_d;
  logic [4:0]  claim_id_q, claim_id_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        err_q, err_d;

  // D fields that carry no meaning for a single-outstanding initiator
  logic unused_d_fields;
  assign unused_d_fields = ^{icm_d_param, icm_d_size, icm_d_source, icm_d_data[31:5]};

  // Constant A-channel fields
  assign icm_a_param   = 3'd0;
  assign icm_a_size    = 4'd2;
  assign icm_a_source  = SOURCE_ID;
  assign icm_a_address = CLAIM_ADDR;
  assign icm_a_mask    = 4'hF;
  assign icm_a_corrupt = 1'b0;

  assign icm_a_valid   = a_valid_q;
  assign icm_a_opcode  = a_opcode_q;
  assign icm_a_data    = a_data_q;
  assign err_o         = err_q;
  assign claim_id_o    = claim_id_q;

  // Handshake outputs decoded purely from the state register
  assign icm_d_ready      = (state_q == CLM_RSP) || (state_q == CMP_RSP);
  assign claim_valid_o    = (state_q == DELIVER);
  assign complete_ready_o = (state_q == WAIT_CMP);

  // Next-state and registered A-channel payload
  always_comb begin
    state_d    = state_q;
    a_valid_d  = a_valid_q;
    a_opcode_d = a_opcode_q;
    a_data_d   = a_data_q;
    claim_id_d = claim_id_q;
    hold_cnt_d = hold_cnt_q;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (irq_i) begin
          state_d    = CLM_REQ;
          a_valid_d  = 1'b1;
          a_opcode_d = OP_GET;
          a_data_d   = '0;
        end
      end
      CLM_REQ: begin
        if (icm_a_ready) begin
          state_d   = CLM_RSP;
          a_valid_d = 1'b0;
        end
      end
      CLM_RSP: begin
        if (icm_d_valid) begin
          if (icm_d_denied || icm_d_corrupt || (icm_d_opcode != OP_ACK_DATA)) begin
            err_d      = 1'b1;
            state_d    = HOLD;
            hold_cnt_d = HOLD_LOAD;
          end else if (icm_d_data[4:0] == 5'd0) begin
            state_d    = HOLD;
            hold_cnt_d = HOLD_LOAD;
          end else begin
            claim_id_d = icm_d_data[4:0];
            state_d    = DELIVER;
          end
        end
      end
      DELIVER: begin
        if (claim_ready_i) state_d = WAIT_CMP;
      end
      WAIT_CMP: begin
        if (complete_valid_i) begin
          state_d    = CMP_REQ;
          a_valid_d  = 1'b1;
          a_opcode_d = OP_PUT_FULL;
          a_data_d   = {27'd0, claim_id_q};
        end
      end
      CMP_REQ: begin
        if (icm_a_ready) begin
          state_d   = CMP_RSP;
          a_valid_d = 1'b0;
        end
      end
      CMP_RSP: begin
        if (icm_d_valid) begin
          if (icm_d_denied || icm_d_corrupt || (icm_d_opcode != OP_ACK)) begin
            err_d      = 1'b1;
            state_d    = HOLD;
            hold_cnt_d = HOLD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        // Stay HOLDOFF cycles in total; leave on the cycle the count hits 1
        if (hold_cnt_q <= 4'd1) begin
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and payload registers, async active-low reset
  always_ff @(posedge icm_clock_i or negedge icm_resetn_i) begin
    if (!icm_resetn_i) begin
      state_q    <= IDLE;
      a_valid_q  <= 1'b0;
      a_opcode_q <= '0;
      a_data_q   <= '0;
      claim_id_q <= '0;
      hold_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_valid_q  <= a_valid_d;
      a_opcode_q <= a_opcode_d;
      a_data_q   <= a_data_d;
      claim_id_q <= claim_id_d;
      hold_cnt_q <= hold_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_plic_claim_master.sv
// Directed bench for plic_claim_master: context 0 and context 1 instances
// share all inputs; the context 1 instance differs only in address and source.
module tb_plic_claim_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_ready = 1'b0;
  logic [2:0]  d_opcode = '0;
  logic [1:0]  d_param = '0;
  logic [3:0]  d_size = 4'd2;
  logic [3:0]  d_source = '0;
  logic        d_denied = 1'b0;
  logic        d_corrupt = 1'b0;
  logic [31:0] d_data = '0;
  logic        d_valid = 1'b0;
  logic        irq = 1'b0;
  logic        claim_ready = 1'b0;
  logic        complete_valid = 1'b0;

  logic [2:0]  a_opcode, a_param, a_opcode_1, a_param_1;
  logic [3:0]  a_size, a_mask, a_size_1, a_mask_1;
  logic [3:0]  a_source, a_source_1;
  logic [21:0] a_address, a_address_1;
  logic [31:0] a_data, a_data_1;
  logic        a_corrupt, a_valid, d_ready, claim_valid, complete_ready, err;
  logic        a_corrupt_1, a_valid_1, d_ready_1, claim_valid_1, complete_ready_1, err_1;
  logic [4:0]  claim_id, claim_id_1;

  int n_checks = 0;
  int n_fail = 0;
  int n_get = 0;
  int n_put = 0;

  always #5 clk = ~clk;

  plic_claim_master #(.TL_RS(4), .SOURCE_ID(4'd0), .CONTEXT(0), .HOLDOFF(4)) dut (
    .icm_clock_i(clk), .icm_resetn_i(rst_n),
    .icm_a_opcode(a_opcode), .icm_a_param(a_param), .icm_a_size(a_size),
    .icm_a_source(a_source), .icm_a_address(a_address), .icm_a_mask(a_mask),
    .icm_a_data(a_data), .icm_a_corrupt(a_corrupt), .icm_a_valid(a_valid),
    .icm_a_ready(a_ready),
    .icm_d_opcode(d_opcode), .icm_d_param(d_param), .icm_d_size(d_size),
    .icm_d_source(d_source), .icm_d_denied(d_denied), .icm_d_corrupt(d_corrupt),
    .icm_d_data(d_data), .icm_d_valid(d_valid), .icm_d_ready(d_ready),
    .irq_i(irq), .claim_valid_o(claim_valid), .claim_id_o(claim_id),
    .claim_ready_i(claim_ready), .complete_valid_i(complete_valid),
    .complete_ready_o(complete_ready), .err_o(err)
  );

  plic_claim_master #(.TL_RS(4), .SOURCE_ID(4'd5), .CONTEXT(1), .HOLDOFF(4)) dut_ctx1 (
    .icm_clock_i(clk), .icm_resetn_i(rst_n),
    .icm_a_opcode(a_opcode_1), .icm_a_param(a_param_1), .icm_a_size(a_size_1),
    .icm_a_source(a_source_1), .icm_a_address(a_address_1), .icm_a_mask(a_mask_1),
    .icm_a_data(a_data_1), .icm_a_corrupt(a_corrupt_1), .icm_a_valid(a_valid_1),
    .icm_a_ready(a_ready),
    .icm_d_opcode(d_opcode), .icm_d_param(d_param), .icm_d_size(d_size),
    .icm_d_source(d_source), .icm_d_denied(d_denied), .icm_d_corrupt(d_corrupt),
    .icm_d_data(d_data), .icm_d_valid(d_valid), .icm_d_ready(d_ready_1),
    .irq_i(irq), .claim_valid_o(claim_valid_1), .claim_id_o(claim_id_1),
    .claim_ready_i(claim_ready), .complete_valid_i(complete_valid),
    .complete_ready_o(complete_ready_1), .err_o(err_1)
  );

  // Count accepted A-channel requests of context 0
  always @(posedge clk) begin
    if (rst_n && a_valid && a_ready) begin
      if (a_opcode == 3'd4) n_get++;
      else n_put++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_ready = 1'b0; d_valid = 1'b0; d_opcode = '0; d_data = '0;
    d_denied = 1'b0; d_corrupt = 1'b0; irq = 1'b0;
    claim_ready = 1'b0; complete_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    step(); step();
    n_checks++;
    if ({a_valid, a_opcode, a_data, d_ready, claim_valid, claim_id, complete_ready, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b op=%0d data=%h dready=%b cv=%b id=%0d cr=%b err=%b, required all 0",
               a_valid, a_opcode, a_data, d_ready, claim_valid, claim_id, complete_ready, err);
    end
    n_checks++;
    if ({a_param, a_size, a_mask, a_corrupt, a_source} !== {3'd0, 4'd2, 4'hF, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL const_fields: param=%0d size=%0d mask=%h corrupt=%b source=%0d, required 0/2/f/0/0",
               a_param, a_size, a_mask, a_corrupt, a_source);
    end
    n_checks++;
    if (a_address !== 22'h200004 || a_address_1 !== 22'h201004 || a_source_1 !== 4'd5) begin
      n_fail++;
      $display("FAIL address_ctx: ctx0=%h ctx1=%h src1=%0d, required 200004/201004/5",
               a_address, a_address_1, a_source_1);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_normal_flow();
    do_reset();
    irq = 1'b1;
    step();
    n_checks++;
    if (a_valid !== 1'b1 || a_opcode !== 3'd4 || a_data !== 32'd0 || a_address !== 22'h200004) begin
      n_fail++;
      $display("FAIL normal_get: valid=%b op=%0d data=%h addr=%h, required 1/4/0/200004",
               a_valid, a_opcode, a_data, a_address);
    end
    n_checks++;
    if (a_valid_1 !== 1'b1 || a_opcode_1 !== 3'd4 || a_address_1 !== 22'h201004) begin
      n_fail++;
      $display("FAIL ctx1_get: valid=%b op=%0d addr=%h, required 1/4/201004", a_valid_1, a_opcode_1, a_address_1);
    end
    a_ready = 1'b1;
    step();
    n_checks++;
    if (a_valid !== 1'b0 || d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL normal_clm_rsp: valid=%b dready=%b, required 0/1", a_valid, d_ready);
    end
    a_ready = 1'b0; irq = 1'b0;
    d_valid = 1'b1; d_opcode = 3'd1; d_data = 32'd7;
    step();
    d_valid = 1'b0;
    n_checks++;
    if (claim_valid !== 1'b1 || claim_id !== 5'd7 || d_ready !== 1'b0 || claim_id_1 !== 5'd7) begin
      n_fail++;
      $display("FAIL normal_deliver: cv=%b id=%0d dready=%b id1=%0d, required 1/7/0/7",
               claim_valid, claim_id, d_ready, claim_id_1);
    end
    claim_ready = 1'b1;
    step();
    claim_ready = 1'b0;
    n_checks++;
    if (claim_valid !== 1'b0 || complete_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL normal_wait_cmp: cv=%b cr=%b, required 0/1", claim_valid, complete_ready);
    end
    complete_valid = 1'b1;
    step();
    complete_valid = 1'b0;
    n_checks++;
    if (a_valid !== 1'b1 || a_opcode !== 3'd0 || a_data !== 32'd7 || a_address !== 22'h200004
        || a_address_1 !== 22'h201004 || a_data_1 !== 32'd7) begin
      n_fail++;
      $display("FAIL normal_put: valid=%b op=%0d data=%h addr=%h addr1=%h data1=%h, required 1/0/7/200004/201004/7",
               a_valid, a_opcode, a_data, a_address, a_address_1, a_data_1);
    end
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    d_valid = 1'b1; d_opcode = 3'd0; d_data = '0;
    step();
    d_valid = 1'b0;
    step();
    n_checks++;
    if (a_valid !== 1'b0 || d_ready !== 1'b0 || err !== 1'b0 || claim_valid !== 1'b0 || complete_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_idle: valid=%b dready=%b err=%b cv=%b cr=%b, required all 0",
               a_valid, d_ready, err, claim_valid, complete_ready);
    end
  endtask

  task automatic test_spurious();
    bit early_get;
    bit any_claim;
    do_reset();
    irq = 1'b1;
    step();
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    d_valid = 1'b1; d_opcode = 3'd1; d_data = 32'hFFFF_FFE0;
    step();
    d_valid = 1'b0;
    early_get = 1'b0;
    any_claim = claim_valid;
    for (int i = 0; i < 4; i++) begin
      step();
      if (a_valid) early_get = 1'b1;
      if (claim_valid) any_claim = 1'b1;
    end
    n_checks++;
    if (early_get !== 1'b0 || any_claim !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_hold: get_during_hold=%b claim_seen=%b, required 0/0", early_get, any_claim);
    end
    step();
    n_checks++;
    if (a_valid !== 1'b1 || a_opcode !== 3'd4) begin
      n_fail++;
      $display("FAIL spurious_regrant: valid=%b op=%0d, required 1/4", a_valid, a_opcode);
    end
  endtask

  task automatic test_backpressure();
    bit unstable;
    int g0, p0;
    do_reset();
    g0 = n_get; p0 = n_put;
    irq = 1'b1;
    step();
    irq = 1'b0;
    unstable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (a_valid !== 1'b1 || a_opcode !== 3'd4 || a_data !== 32'd0) unstable = 1'b1;
      step();
    end
    n_checks++;
    if (unstable !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_get_stable: unstable=%b, required 0", unstable);
    end
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    d_valid = 1'b1; d_opcode = 3'd1; d_data = 32'hABCD_00E9;
    claim_ready = 1'b1;
    step();
    d_valid = 1'b0;
    n_checks++;
    if (claim_id !== 5'd9 || claim_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_claim_id: id=%0d cv=%b, required 9/1", claim_id, claim_valid);
    end
    step();
    claim_ready = 1'b0;
    complete_valid = 1'b1;
    step();
    complete_valid = 1'b0;
    unstable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (a_valid !== 1'b1 || a_opcode !== 3'd0 || a_data !== 32'd9) unstable = 1'b1;
      step();
    end
    n_checks++;
    if (unstable !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_put_stable: unstable=%b, required 0", unstable);
    end
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    d_valid = 1'b1; d_opcode = 3'd0;
    step();
    d_valid = 1'b0;
    step(); step();
    n_checks++;
    if (n_get - g0 !== 1 || n_put - p0 !== 1 || a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_counts: gets=%0d puts=%0d valid=%b, required 1/1/0", n_get - g0, n_put - p0, a_valid);
    end
  endtask

  task automatic test_error();
    logic [2:0] rsp_op [2];
    logic       rsp_den [2];
    rsp_op[0] = 3'd1; rsp_den[0] = 1'b1;
    rsp_op[1] = 3'd0; rsp_den[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      irq = 1'b1;
      step();
      a_ready = 1'b1;
      step();
      a_ready = 1'b0; irq = 1'b0;
      d_valid = 1'b1; d_opcode = rsp_op[k]; d_denied = rsp_den[k]; d_data = 32'd5;
      step();
      d_valid = 1'b0; d_denied = 1'b0;
      n_checks++;
      if (err !== 1'b1 || claim_valid !== 1'b0 || d_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL error_pulse[%0d]: err=%b cv=%b dready=%b, required 1/0/0", k, err, claim_valid, d_ready);
      end
      step();
      n_checks++;
      if (err !== 1'b0 || claim_valid !== 1'b0 || a_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL error_after[%0d]: err=%b cv=%b valid=%b, required 0/0/0", k, err, claim_valid, a_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    irq = 1'b1;
    step();
    a_ready = 1'b1;
    step();
    a_ready = 1'b0; irq = 1'b0;
    d_valid = 1'b1; d_opcode = 3'd1; d_data = 32'd3;
    step();
    d_valid = 1'b0;
    n_checks++;
    if (claim_valid !== 1'b1 || claim_id !== 5'd3) begin
      n_fail++;
      $display("FAIL async_pre: cv=%b id=%0d, required 1/3", claim_valid, claim_id);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (claim_valid !== 1'b0 || claim_id !== 5'd0 || a_valid !== 1'b0 || complete_ready !== 1'b0 || d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: cv=%b id=%0d valid=%b cr=%b dready=%b, required all 0",
               claim_valid, claim_id, a_valid, complete_ready, d_ready);
    end
    step();
    rst_n = 1'b1;
    irq = 1'b1;
    step();
    n_checks++;
    if (a_valid !== 1'b1 || a_opcode !== 3'd4 || a_data !== 32'd0) begin
      n_fail++;
      $display("FAIL async_fresh_get: valid=%b op=%0d data=%h, required 1/4/0", a_valid, a_opcode, a_data);
    end
  endtask

  initial begin
    test_reset();
    test_normal_flow();
    test_spurious();
    test_backpressure();
    test_error();
    test_async_reset();
    clear_inputs();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plic_claim_master.md
# plic_claim_master

TileLink-UL initiator that services one PLIC hart context on behalf of a core. When the context's interrupt line rises it issues a Get to the context's claim register, hands the returned source ID to the core, waits for the core to finish, then issues a PutFullData of that ID to the same register to complete the interrupt. It sits between the core's interrupt unit and the PLIC's TileLink slave port, one instance per context.

## Interface
- TL_RS, 4: width of a_source/d_source.
- SOURCE_ID, 0: constant a_source driven on every request.
- CONTEXT, 0: PLIC context serviced (0 or 1); selects address bit 12.
- HOLDOFF, 4: idle cycles enforced after a spurious (ID 0) claim or an error, range 1..15.
- icm_clock_i  in  1  clock; all logic on rising edge.
- icm_resetn_i  in  1  reset; asynchronous, active-low.
- icm_a_opcode  out  3  4 = Get, 0 = PutFullData.
- icm_a_param  out  3  always 0.
- icm_a_size  out  4  always 2 (4 bytes).
- icm_a_source  out  TL_RS  always SOURCE_ID.
- icm_a_address  out  22  0x200004 | (CONTEXT<<12).
- icm_a_mask  out  4  always 4'hF.
- icm_a_data  out  32  {27'h0, id} on Put; 0 on Get.
- icm_a_corrupt  out  1  always 0.
- icm_a_valid / icm_a_ready  out / in  1  A-channel handshake.
- icm_d_opcode  in  3  1 = AccessAckData, 0 = AccessAck.
- icm_d_param, icm_d_size, icm_d_source  in  2/4/TL_RS  ignored.
- icm_d_denied, icm_d_corrupt  in  1  error indications.
- icm_d_data  in  32  claim result; bits [4:0] used.
- icm_d_valid / icm_d_ready  in / out  1  D-channel handshake.
- irq_i  in  1  level interrupt from PLIC for this context.
- claim_valid_o  out  1  claimed ID available to core.
- claim_id_o  out  5  claimed source ID, stable while claim_valid_o.
- claim_ready_i  in  1  core accepts ID.
- complete_valid_i  in  1  core finished handler.
- complete_ready_o  out  1  block accepts completion.
- err_o  out  1  one-cycle pulse on denied/corrupt/unexpected D opcode.

## Operation
- States: IDLE, CLM_REQ, CLM_RSP, DELIVER, WAIT_CMP, CMP_REQ, CMP_RSP, HOLD.
- IDLE: irq_i=1 -> CLM_REQ (a_valid=1, opcode 4).
- CLM_REQ: a_valid&a_ready -> CLM_RSP.
- CLM_RSP: d_ready=1. On d_valid: denied|corrupt|opcode!=1 -> err_o pulse, HOLD. d_data[4:0]==0 -> HOLD (spurious, no delivery, no completion). Else latch id -> DELIVER.
- DELIVER: claim_valid_o=1; claim_ready_i -> WAIT_CMP.
- WAIT_CMP: complete_ready_o=1; complete_valid_i -> CMP_REQ (opcode 0, data = latched id; complete_id not taken from core, exactly one completion per claim).
- CMP_REQ: a_valid&a_ready -> CMP_RSP.
- CMP_RSP: d_ready=1. On d_valid: denied|corrupt|opcode!=0 -> err_o pulse, HOLD; else IDLE.
- HOLD: 4-bit counter loads HOLDOFF on entry, decrements each cycle, -> IDLE at 0; irq_i ignored meanwhile.
- Exactly one transaction outstanding; any D beat in a RSP state is consumed, d_source not checked. d_ready=0 in all other states; a D beat then is not accepted.
- irq_i dropping after CLM_REQ entered does not abort; flow runs to completion or spurious path.

## Timing
- Reset (icm_resetn_i=0, async): state IDLE, a_valid 0, a_opcode 0, a_data 0, d_ready 0, claim_valid_o 0, claim_id_o 0, complete_ready_o 0, err_o 0, hold counter 0.
- All A outputs registered; a_valid held with payload stable until a_ready (no retraction).
- d_ready, claim_valid_o, complete_ready_o decoded from state register (no input-to-output comb path).
- irq_i high in IDLE at edge N -> a_valid=1 after edge N+1 only if IDLE; i.e. a_valid visible cycle N+1.
- a_ready same cycle as a_valid -> RSP state next cycle; d_valid in first RSP cycle accepted that cycle.
- d_valid with claim ID at edge M -> claim_valid_o=1 from cycle M+1.
- Best-case irq-to-claim_valid: 3 cycles against a zero-wait slave (PLIC slave responds one cycle after acceptance -> 4).
- claim_ready_i and complete_valid_i may be asserted early; only sampled in DELIVER/WAIT_CMP.
- Reset asserted mid-transaction: block returns to IDLE immediately; the PLIC-side transaction is abandoned (system reset resets both).

## Test plan
- Normal flow: irq_i=1, slave returns AccessAckData data=7 -> Get at 0x200004, claim_id_o=7, after complete_valid_i Put at 0x200004 data=7, then IDLE.
- CONTEXT=1: same flow -> both requests at address 0x201004.
- Spurious: claim returns 0 -> no claim_valid_o, no Put, irq_i ignored for HOLDOFF=4 cycles, then new Get.
- Backpressure: a_ready low 5 cycles on both requests -> a_valid/payload stable throughout, single Get and single Put issued.
- Error: d_denied=1 on claim response -> err_o one-cycle pulse, HOLD, no delivery; same for d_opcode=0 on Get.
- Async reset asserted in DELIVER -> outputs to reset values without a clock edge; after release with irq_i=1, fresh Get.
